// File: rtl/trace_match_checker.sv
// trace_match_checker
// Captures a 4x4 target trace from the generator, shows it for a fixed time,
// collects the player's cell marks, then judges the drawn mask against the
// target and keeps a saturating score of passed rounds.
// Cell index n = row*4 + col, bit n of the 16-bit trace/mask.

module trace_match_checker #(
    parameter int SHOW_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter int SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               save_trace,
    input  logic [15:0]        trace,
    output logic               trace_saved,
    input  logic               cell_valid,
    input  logic [3:0]         cell_idx,
    input  logic               submit,
    output logic [15:0]        display,
    output logic               show_phase,
    output logic               input_phase,
    output logic               result_valid,
    output logic               pass,
    output logic [SCORE_W-1:0] score
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_INPUT  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t             state_r,     state_s;
    logic [15:0]        target_r,    target_s;
    logic [15:0]        mask_r,      mask_s;
    logic [TW-1:0]      timer_r,     timer_s;
    logic               timed_out_r, timed_out_s;
    logic               pass_r,      pass_s;
    logic [SCORE_W-1:0] score_r,     score_s;
    logic               ack_r,       ack_s;
    logic               rvalid_r,    rvalid_s;
    logic [15:0]        display_r,   display_s;
    logic               show_r,      show_s;
    logic               input_r,     input_s;

    // One-hot decode of a grid cell index into a 16-bit mask bit.
    function automatic logic [15:0] cell_bit(input logic [3:0] idx);
        cell_bit = 16'h0001 << idx;
    endfunction

    // Next-state and next-output logic; outputs are derived from the next state
    // so that the registered phase/display outputs line up with the state.
    always_comb begin
        state_s     = state_r;
        target_s    = target_r;
        mask_s      = mask_r;
        timer_s     = timer_r;
        timed_out_s = timed_out_r;
        pass_s      = pass_r;
        score_s     = score_r;
        ack_s       = 1'b0;
        rvalid_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (save_trace) begin
                    target_s = trace;
                    timer_s  = {TW{1'b0}};
                    ack_s    = 1'b1;
                    state_s  = ST_SHOW;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (timer_r == SHOW_LAST) begin
                    timer_s = {TW{1'b0}};
                    mask_s  = 16'h0000;
                    state_s = ST_INPUT;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            ST_INPUT: begin
                // A mark in the submit/timeout cycle still counts toward the verdict.
                if (cell_valid) begin
                    mask_s = mask_r | cell_bit(cell_idx);
                end else begin
                    mask_s = mask_r;
                end
                if (submit) begin
                    timed_out_s = 1'b0;
                    state_s     = ST_RESULT;
                end else if (timer_r == TIMEOUT_LAST) begin
                    timed_out_s = 1'b1;
                    state_s     = ST_RESULT;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            ST_RESULT: begin
                pass_s   = (mask_r == target_r) && !timed_out_r;
                rvalid_s = 1'b1;
                if (pass_s && (score_r != {SCORE_W{1'b1}})) begin
                    score_s = score_r + 1'b1;
                end else begin
                    score_s = score_r;
                end
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        case (state_s)
            ST_SHOW:  display_s = target_s;
            ST_INPUT: display_s = mask_s;
            default:  display_s = 16'h0000;
        endcase
        show_s  = (state_s == ST_SHOW);
        input_s = (state_s == ST_INPUT);
    end

    // State, datapath and output registers; reset discards any round in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            target_r    <= 16'h0000;
            mask_r      <= 16'h0000;
            timer_r     <= {TW{1'b0}};
            timed_out_r <= 1'b0;
            pass_r      <= 1'b0;
            score_r     <= {SCORE_W{1'b0}};
            ack_r       <= 1'b0;
            rvalid_r    <= 1'b0;
            display_r   <= 16'h0000;
            show_r      <= 1'b0;
            input_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            target_r    <= target_s;
            mask_r      <= mask_s;
            timer_r     <= timer_s;
            timed_out_r <= timed_out_s;
            pass_r      <= pass_s;
            score_r     <= score_s;
            ack_r       <= ack_s;
            rvalid_r    <= rvalid_s;
            display_r   <= display_s;
            show_r      <= show_s;
            input_r     <= input_s;
        end
    end

    assign trace_saved  = ack_r;
    assign result_valid = rvalid_r;
    assign pass         = pass_r;
    assign score        = score_r;
    assign display      = display_r;
    assign show_phase   = show_r;
    assign input_phase  = input_r;

endmodule

// File: tb/tb_trace_match_checker.sv
// Directed testbench for trace_match_checker with short show/timeout windows
// and a 2-bit score so saturation is reachable quickly.

module tb_trace_match_checker;

    localparam int SHOW_CYCLES    = 4;
    localparam int TIMEOUT_CYCLES = 10;
    localparam int SCORE_W        = 2;

    logic               clk;
    logic               resetn;
    logic               save_trace;
    logic [15:0]        trace;
    logic               trace_saved;
    logic               cell_valid;
    logic [3:0]         cell_idx;
    logic               submit;
    logic [15:0]        display;
    logic               show_phase;
    logic               input_phase;
    logic               result_valid;
    logic               pass;
    logic [SCORE_W-1:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    trace_match_checker #(
        .SHOW_CYCLES   (SHOW_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SCORE_W       (SCORE_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .save_trace  (save_trace),
        .trace       (trace),
        .trace_saved (trace_saved),
        .cell_valid  (cell_valid),
        .cell_idx    (cell_idx),
        .submit      (submit),
        .display     (display),
        .show_phase  (show_phase),
        .input_phase (input_phase),
        .result_valid(result_valid),
        .pass        (pass),
        .score       (score)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture trace and run through the show phase into input
    task automatic start_round(input logic [15:0] t);
        save_trace = 1'b1;
        trace      = t;
        tick();
        check("ack", {31'd0, trace_saved}, 32'd1);
        save_trace = 1'b0;
        repeat (SHOW_CYCLES) tick();
        check("in_input", {31'd0, input_phase}, 32'd1);
    endtask

    task automatic mark(input logic [3:0] idx);
        cell_valid = 1'b1;
        cell_idx   = idx;
        tick();
        cell_valid = 1'b0;
    endtask

    // Submit (optionally with a same-cycle mark) and check the verdict pulse
    task automatic finish_round(input logic with_cell, input logic [3:0] idx,
                                input logic exp_pass, input int exp_score);
        submit     = 1'b1;
        cell_valid = with_cell;
        cell_idx   = idx;
        tick();
        submit     = 1'b0;
        cell_valid = 1'b0;
        check("rv_early", {31'd0, result_valid}, 32'd0);
        tick();
        check("rv", {31'd0, result_valid}, 32'd1);
        check("pass", {31'd0, pass}, {31'd0, exp_pass});
        check("score", {30'd0, score}, 32'(exp_score));
        tick();
        check("rv_one", {31'd0, result_valid}, 32'd0);
        check("pass_hold", {31'd0, pass}, {31'd0, exp_pass});
    endtask

    initial begin
        resetn     = 1'b0;
        save_trace = 1'b0;
        trace      = 16'h0000;
        cell_valid = 1'b0;
        cell_idx   = 4'd0;
        submit     = 1'b0;
        repeat (2) tick();
        check("rst_disp", {16'd0, display}, 32'd0);
        check("rst_score", {30'd0, score}, 32'd0);
        check("rst_flags", {26'd0, trace_saved, show_phase, input_phase, result_valid, pass, 1'b0}, 32'd0);
        resetn = 1'b1;
        tick();

        // 1: handshake and show timing
        save_trace = 1'b1;
        trace      = 16'h0137;
        tick();
        check("h_ack", {31'd0, trace_saved}, 32'd1);
        check("h_show0", {31'd0, show_phase}, 32'd1);
        check("h_disp0", {16'd0, display}, 32'h0137);
        save_trace = 1'b0;
        for (int i = 1; i < SHOW_CYCLES; i++) begin
            tick();
            check("h_ack_low", {31'd0, trace_saved}, 32'd0);
            check("h_show", {31'd0, show_phase}, 32'd1);
            check("h_disp", {16'd0, display}, 32'h0137);
        end
        tick();
        check("h_show_end", {31'd0, show_phase}, 32'd0);
        check("h_input", {31'd0, input_phase}, 32'd1);
        check("h_disp_in", {16'd0, display}, 32'h0000);

        // 2: pass
        mark(4'd0); mark(4'd1); mark(4'd2); mark(4'd4); mark(4'd5); mark(4'd8);
        check("p_mask", {16'd0, display}, 32'h0137);
        finish_round(1'b0, 4'd0, 1'b1, 1);

        // 3: extra cell fails; same-cycle last cell + submit passes
        start_round(16'h0137);
        mark(4'd0); mark(4'd1); mark(4'd2); mark(4'd4); mark(4'd5); mark(4'd8); mark(4'd15);
        check("f_mask", {16'd0, display}, 32'h8137);
        finish_round(1'b0, 4'd0, 1'b0, 1);
        start_round(16'h0137);
        mark(4'd0); mark(4'd0); mark(4'd1); mark(4'd2); mark(4'd4); mark(4'd5);
        check("s_mask", {16'd0, display}, 32'h0037);
        finish_round(1'b1, 4'd8, 1'b1, 2);

        // 4: timeout with correct mask still fails
        start_round(16'h0137);
        mark(4'd0); mark(4'd1); mark(4'd2); mark(4'd4); mark(4'd5); mark(4'd8);
        repeat (TIMEOUT_CYCLES - 7) begin
            tick();
            check("t_input", {31'd0, input_phase}, 32'd1);
        end
        tick();
        check("t_left", {31'd0, input_phase}, 32'd0);
        check("t_rv_early", {31'd0, result_valid}, 32'd0);
        tick();
        check("t_rv", {31'd0, result_valid}, 32'd1);
        check("t_pass", {31'd0, pass}, 32'd0);
        check("t_score", {30'd0, score}, 32'd2);

        // 6: save_trace during SHOW ignored; reset mid-INPUT clears everything
        tick();
        save_trace = 1'b1;
        trace      = 16'h00F0;
        tick();
        check("r_ack", {31'd0, trace_saved}, 32'd1);
        save_trace = 1'b0;
        tick();
        save_trace = 1'b1;
        trace      = 16'hFFFF;
        tick();
        check("r_noack", {31'd0, trace_saved}, 32'd0);
        check("r_disp", {16'd0, display}, 32'h00F0);
        save_trace = 1'b0;
        repeat (2) tick();
        check("r_input", {31'd0, input_phase}, 32'd1);
        mark(4'd3);
        check("r_mask", {16'd0, display}, 32'h0008);
        #2;
        resetn = 1'b0;
        #1;
        check("r_disp0", {16'd0, display}, 32'd0);
        check("r_score0", {30'd0, score}, 32'd0);
        check("r_flags0", {27'd0, trace_saved, show_phase, input_phase, result_valid, pass}, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        check("r_idle", {30'd0, show_phase, input_phase}, 32'd0);

        // 5: saturation across four passes (includes an empty trace)
        start_round(16'h8001);
        mark(4'd15); mark(4'd0);
        finish_round(1'b0, 4'd0, 1'b1, 1);
        start_round(16'h0000);
        finish_round(1'b0, 4'd0, 1'b1, 2);
        start_round(16'h0137);
        mark(4'd0); mark(4'd1); mark(4'd2); mark(4'd4); mark(4'd5); mark(4'd8);
        finish_round(1'b0, 4'd0, 1'b1, 3);
        start_round(16'h0000);
        finish_round(1'b0, 4'd0, 1'b1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
